mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (F stage) and data access (M stage) in the 4-stage core.
- Grants requests, sequences one outstanding memory transaction at a time and formats store data and byte masks from funct3.
- Returns read data and completion to the right requester and drives per-requester stall signals into pipeline control.
- Sits between F/M stage logic and the memory; load result formatting stays in the M/W stage load path.

Parameters:
- MAX_DATA_STREAK, 4, number of consecutive data grants allowed while fetch is waiting before fetch is forced to win (1..15).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request; held with if_addr until if_rvalid
- if_addr  input  32  fetch byte address, word-aligned
- if_rvalid  output  1  fetch complete; if_rdata valid this cycle
- if_rdata  output  32  fetched instruction
- if_stall  output  1  if_req high and fetch not completing this cycle
- dm_req  input  1  data request; held with all dm_* inputs until dm_rvalid
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  32  data byte address
- dm_wdata  input  32  unformatted store data (rs2)
- dm_funct3  input  3  access size from the M-stage instruction
- dm_rvalid  output  1  data access complete (loads and stores)
- dm_rdata  output  32  raw word read; 0 for stores and misaligned accesses
- dm_stall  output  1  dm_req high and data not completing this cycle
- dm_misalign  output  1  combinational misalignment flag for the current dm request
- mem_req  output  1  memory request; held until mem_gnt
- mem_we  output  1  write enable
- mem_addr  output  32  word address ({addr[31:2],2'b00})
- mem_wdata  output  32  lane-replicated store data
- mem_wmask  output  4  byte write mask; 0000 on reads
- mem_gnt  input  1  memory accepted request this cycle
- mem_rvalid  input  1  response valid; arrives ≥1 cycle after mem_gnt
- mem_rdata  input  32  response data

Behaviour:
- States: IDLE, WAIT_D, WAIT_I, MISAL. Reset: state=IDLE, streak=0. With no requests, all outputs are 0.
- IDLE arbitration (combinational):
  - Data wins when dm_req is high, unless if_req is high and streak==MAX_DATA_STREAK; then fetch wins.
  - If only one request is high, it wins.
- IDLE, data winner misaligned (SH with addr[0]=1; SW or LW/LH/LHU with the corresponding alignment violated): mem_req=0; next state MISAL.
- IDLE, otherwise: mem_req=1 with the winner's fields. Next state is WAIT_D or WAIT_I only in a cycle where mem_gnt=1; else stay in IDLE and re-arbitrate next cycle.
- WAIT_x: mem_req=0. When mem_rvalid=1:
  - x_rvalid=1 and x_rdata=mem_rdata the same cycle; dm_rdata=0 if dm_we.
  - Next state IDLE.
- MISAL: dm_rvalid=1, dm_rdata=0 for one cycle; next state IDLE.
- Throughput: minimum 2 cycles per transaction (grant, response). The next grant is possible in the cycle after rvalid.
- Streak update on each data grant (mem_gnt, or entry to MISAL):
  - streak+1 (saturating) if if_req is high that cycle; else 0.
  - A fetch grant sets streak=0.
- Store formatting:
  - SB: wmask=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wmask=0011<<{addr[1],0}, wdata={2{wdata[15:0]}}.
  - SW: wmask=1111, wdata=wdata.
  - Loads: wmask=0000.
  - Other funct3 values on a store: treated as SW.
- mem_rvalid in IDLE or MISAL: ignored. This covers a response outstanding across reset.
- rst mid-transaction: immediate return to IDLE, streak=0, and no rvalid is produced for the aborted request. Requesters re-issue after reset.
- Stalls: if_stall = if_req & ~if_rvalid; dm_stall = dm_req & ~dm_rvalid.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE/WAIT_D/WAIT_I/MISAL)
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - streak counter width (4)
- Sub-module store_formatter: combinational (funct3, addr[1:0], wdata, we) → (wmask, wdata_out, misalign).

Test Plan:
- Fetch only: if_req, if_addr=0x100, mem_gnt same cycle, mem_rvalid 2 cycles later with 0x00000013 → if_rvalid=1, if_rdata=0x00000013; if_stall high for 2 cycles.
- Simultaneous if_req and dm_req (LW 0x200) → data granted first with mem_addr=0x200; fetch granted in the cycle after dm_rvalid.
- SB dm_addr=0x203, dm_wdata=0xAB → mem_wmask=1000, mem_wdata=0xABABABAB. SH addr 0x202, wdata 0x1234 → wmask=1100, wdata=0x12341234.
- SW to 0x201 → mem_req never asserted, dm_misalign=1, dm_rvalid=1 with rdata=0 one cycle after request.
- dm_req continuous with if_req held, MAX_DATA_STREAK=4 → exactly 4 data grants, then a fetch grant, then streak restarts.
- rst asserted in WAIT_D, then mem_rvalid pulses after reset → no dm_rvalid, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Covers the FSM encoding, the RISC-V funct3 access sizes and the data-streak counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_D = 2'd1,
        ST_WAIT_I = 2'd2,
        ST_MISAL  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int STREAK_W = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_store_formatter.sv
// Combinational store lane formatting and alignment check for one data access.
// Loads produce an empty mask; stores with an unknown funct3 behave as word stores.
module store_formatter
    import mem_arb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_wmask    = 4'b0000;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        if (i_we) begin
            case (i_funct3)
                F3_B: begin
                    o_wmask = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_wmask    = 4'b0011 << {i_addr_lo[1], 1'b0};
                    o_wdata    = {2{i_wdata[15:0]}};
                    o_misalign = i_addr_lo[0];
                end
                default: begin
                    o_wmask    = 4'b1111;
                    o_misalign = |i_addr_lo;
                end
            endcase
        end else begin
            // Byte loads and unknown load sizes never trap on alignment.
            case (i_funct3)
                F3_H, F3_HU: o_misalign = i_addr_lo[0];
                F3_W:        o_misalign = |i_addr_lo;
                F3_B, F3_BU: o_misalign = 1'b0;
                default:     o_misalign = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-ported memory, one transaction in flight.
// Data normally wins; a waiting fetch is forced through after MAX_DATA_STREAK data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_funct3,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        dm_misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output state_t      dbg_state
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

    state_t              r_state;
    state_t              w_next;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_next;
    logic [STREAK_W-1:0] w_streak_bump;
    logic                w_data_win;
    logic [3:0]          w_fmt_wmask;
    logic [31:0]         w_fmt_wdata;
    logic                w_misalign;

    store_formatter u_fmt (
        .i_funct3   (dm_funct3),
        .i_addr_lo  (dm_addr[1:0]),
        .i_wdata    (dm_wdata),
        .i_we       (dm_we),
        .o_wmask    (w_fmt_wmask),
        .o_wdata    (w_fmt_wdata),
        .o_misalign (w_misalign)
    );

    assign w_data_win    = dm_req & ~(if_req & (r_streak == STREAK_MAX));
    assign w_streak_bump = !if_req ? '0 :
                           (r_streak == STREAK_SAT) ? r_streak : r_streak + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_next;
            r_streak <= w_streak_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_streak_next = r_streak;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        mem_wmask     = 4'b0000;
        if_rvalid     = 1'b0;
        if_rdata      = 32'h0;
        dm_rvalid     = 1'b0;
        dm_rdata      = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_data_win) begin
                    if (w_misalign) begin
                        w_next        = ST_MISAL;
                        w_streak_next = w_streak_bump;
                    end else begin
                        mem_req   = 1'b1;
                        mem_we    = dm_we;
                        mem_addr  = word_addr(dm_addr);
                        mem_wdata = dm_we ? w_fmt_wdata : 32'h0;
                        mem_wmask = w_fmt_wmask;
                        if (mem_gnt) begin
                            w_next        = ST_WAIT_D;
                            w_streak_next = w_streak_bump;
                        end
                    end
                end else if (if_req) begin
                    mem_req  = 1'b1;
                    mem_addr = word_addr(if_addr);
                    if (mem_gnt) begin
                        w_next        = ST_WAIT_I;
                        w_streak_next = '0;
                    end
                end
            end
            ST_WAIT_D: begin
                if (mem_rvalid) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = dm_we ? 32'h0 : mem_rdata;
                    w_next    = ST_IDLE;
                end
            end
            ST_WAIT_I: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    w_next    = ST_IDLE;
                end
            end
            ST_MISAL: begin
                dm_rvalid = 1'b1;
                w_next    = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign if_stall    = if_req & ~if_rvalid;
    assign dm_stall    = dm_req & ~dm_rvalid;
    assign dm_misalign = dm_req & w_misalign;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bench drives the memory side cycle by cycle,
// and a negedge monitor checks returned read data against per-requester expected queues.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_funct3;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        dm_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    state_t      dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];

    mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_funct3(dm_funct3), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .dm_stall(dm_stall), .dm_misalign(dm_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
                        if_rvalid, if_rdata, if_stall, dm_rvalid, dm_rdata,
                        dm_stall, dm_misalign} != 0), 32'h0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic data_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata, input logic [31:0] rdata,
                            input int gnt_delay);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_funct3 = f3;
        mem_gnt = 1'b0;
        for (int i = 0; i < gnt_delay; i++) begin
            sample();
            check("d_req_held", 32'(mem_req), 32'h1);
            check("d_stall_wait", 32'(dm_stall), 32'h1);
            tick();
        end
        mem_gnt = 1'b1;
        sample();
        check("d_mem_req", 32'(mem_req), 32'h1);
        check("d_mem_we", 32'(mem_we), 32'(we));
        check("d_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("d_mem_wmask", 32'(mem_wmask), 32'(exp_mask));
        if (we) check("d_mem_wdata", mem_wdata, exp_wdata);
        check("d_misalign", 32'(dm_misalign), 32'h0);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        dm_exp_q.push_back(we ? 32'h0 : rdata);
        sample();
        check("d_done_stall", 32'(dm_stall), 32'h0);
        check("d_done_memreq", 32'(mem_req), 32'h0);
        tick();
        dm_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic misal_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = 32'hFFFF_FFFF; dm_funct3 = f3;
        sample();
        check("m_mem_req", 32'(mem_req), 32'h0);
        check("m_flag", 32'(dm_misalign), 32'h1);
        check("m_no_rvalid_yet", 32'(dm_rvalid), 32'h0);
        tick();
        dm_exp_q.push_back(32'h0);
        sample();
        check("m_rvalid", 32'(dm_rvalid), 32'h1);
        check("m_mem_req2", 32'(mem_req), 32'h0);
        tick();
        dm_req = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (if_exp_q.size() == 0) check("if_spurious_rvalid", 32'(if_rvalid), 32'h0);
            else check("if_rdata", if_rdata, if_exp_q.pop_front());
        end
        if (dm_rvalid) begin
            if (dm_exp_q.size() == 0) check("dm_spurious_rvalid", 32'(dm_rvalid), 32'h0);
            else check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
        end
    end

    // ---------------- directed sequence ----------------
    logic exp_fetch;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; dm_funct3 = 3'b000;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick();
        sample();
        check_quiet("reset_quiet");
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        rst = 1'b0;
        sample();
        check_quiet("idle_quiet");

        // Fetch only: grant same cycle, response two cycles later.
        tick();
        if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
        sample();
        check("f_mem_req", 32'(mem_req), 32'h1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_wmask", 32'(mem_wmask), 32'h0);
        check("f_stall_c0", 32'(if_stall), 32'h1);
        tick();
        mem_gnt = 1'b0;
        sample();
        check("f_mem_req_wait", 32'(mem_req), 32'h0);
        check("f_stall_c1", 32'(if_stall), 32'h1);
        check("f_state", 32'(dbg_state), 32'(ST_WAIT_I));
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        if_exp_q.push_back(32'h0000_0013);
        sample();
        check("f_rvalid", 32'(if_rvalid), 32'h1);
        check("f_stall_done", 32'(if_stall), 32'h0);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        sample();
        check_quiet("f_after_quiet");

        // Simultaneous fetch and LW: data first, fetch right after dm_rvalid.
        tick();
        if_req = 1'b1; if_addr = 32'h104;
        data_txn(1'b0, 32'h200, 32'h0, F3_W, 4'b0000, 32'h0, 32'hCAFE_F00D, 0);
        mem_gnt = 1'b1;
        sample();
        check("both_fetch_req", 32'(mem_req), 32'h1);
        check("both_fetch_addr", mem_addr, 32'h104);
        check("both_fetch_we", 32'(mem_we), 32'h0);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
        if_exp_q.push_back(32'h0010_0093);
        sample();
        check("both_fetch_rvalid", 32'(if_rvalid), 32'h1);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Store formatting and loads, some with a delayed grant.
        data_txn(1'b1, 32'h203, 32'h1234_56AB, F3_B, 4'b1000, 32'hABAB_ABAB, 32'hFFFF_FFFF, 0);
        data_txn(1'b1, 32'h202, 32'hDEAD_1234, F3_H, 4'b1100, 32'h1234_1234, 32'h5555_5555, 1);
        data_txn(1'b1, 32'h201, 32'h0000_00CD, F3_B, 4'b0010, 32'hCDCD_CDCD, 32'h0, 0);
        data_txn(1'b1, 32'h204, 32'h89AB_CDEF, F3_W, 4'b1111, 32'h89AB_CDEF, 32'h0, 2);
        data_txn(1'b1, 32'h208, 32'h0BAD_BEEF, 3'b111, 4'b1111, 32'h0BAD_BEEF, 32'h0, 0);
        data_txn(1'b1, 32'h200, 32'h0000_BEEF, F3_H, 4'b0011, 32'hBEEF_BEEF, 32'h0, 0);
        data_txn(1'b0, 32'h203, 32'h0, F3_BU, 4'b0000, 32'h0, 32'h1122_3344, 0);
        data_txn(1'b0, 32'h206, 32'h0, F3_HU, 4'b0000, 32'h0, 32'h7788_99AA, 1);

        // Misaligned accesses complete without touching memory.
        misal_txn(1'b1, 32'h201, F3_W);
        misal_txn(1'b0, 32'h203, F3_H);
        misal_txn(1'b1, 32'h205, F3_H);
        misal_txn(1'b0, 32'h202, F3_W);

        // Data streak limit: 4 data grants then one fetch, twice.
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_funct3 = F3_W;
        mem_gnt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_fetch = ((k % 5) == 4);
            sample();
            check("streak_req", 32'(mem_req), 32'h1);
            check("streak_addr", mem_addr, exp_fetch ? 32'h400 : 32'h300);
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
            if (exp_fetch) if_exp_q.push_back(32'hA000_0000 + 32'(k));
            else dm_exp_q.push_back(32'hA000_0000 + 32'(k));
            sample();
            check("streak_if_stall", 32'(if_stall), 32'(!exp_fetch));
            check("streak_dm_stall", 32'(dm_stall), 32'(exp_fetch));
            tick();
            mem_rvalid = 1'b0; mem_gnt = 1'b1;
        end
        mem_gnt = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_rdata = 32'h0;
        sample();
        check_quiet("streak_after_quiet");

        // Reset while waiting on a data response; late response must be dropped.
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h208; dm_funct3 = F3_W; mem_gnt = 1'b1;
        sample();
        check("rst_pre_req", 32'(mem_req), 32'h1);
        tick();
        mem_gnt = 1'b0;
        sample();
        check("rst_pre_state", 32'(dbg_state), 32'(ST_WAIT_D));
        tick();
        rst = 1'b1; dm_req = 1'b0;
        #1;
        check("rst_async_state", 32'(dbg_state), 32'(ST_IDLE));
        sample();
        check_quiet("rst_quiet");
        tick();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
        sample();
        check("rst_late_no_rvalid", 32'(dm_rvalid), 32'h0);
        check("rst_late_state", 32'(dbg_state), 32'(ST_IDLE));
        check_quiet("rst_late_quiet");
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        data_txn(1'b0, 32'h208, 32'h0, F3_W, 4'b0000, 32'h0, 32'h600D_600D, 0);

        sample();
        check("if_queue_drained", 32'(if_exp_q.size()), 32'h0);
        check("dm_queue_drained", 32'(dm_exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
